instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//   Parametrised instruction source for top_level. It replaces bench-driven instruction_i with a loadable
//   instruction memory, a program counter and a prefetch FIFO. Instructions are presented on a valid/ready
//   handshake, and the core can redirect fetch on a taken branch or jump.
// PARAMETERS
//   XLEN        32  instruction and PC width
//   IMEM_DEPTH  64  instruction memory words (power of 2, >=2); AW = $clog2(IMEM_DEPTH)
//   FIFO_DEPTH  4   prefetch FIFO entries (power of 2, >=2); CW = $clog2(FIFO_DEPTH+1)
//   RESET_PC    0   PC after reset (word aligned)
// PORTS
//   clock_i        in   1     rising-edge clock
//   resetb_i       in   1     asynchronous active-low reset
//   load_ena_i     in   1     write load_data_i to IMEM[load_addr_i]
//   load_addr_i    in   AW    IMEM word address for load
//   load_data_i    in   XLEN  instruction word to load
//   run_i          in   1     1 = fetching enabled; 0 = fetch paused, FIFO contents kept
//   redirect_i     in   1     flush and restart fetch at redirect_pc_i
//   redirect_pc_i  in   XLEN  new PC (bits [1:0] ignored, treated as 0)
//   instr_valid_o  out  1     FIFO head holds a valid instruction
//   instr_ready_i  in   1     consumer accepts head when instr_valid_o=1
//   instruction_o  out  XLEN  FIFO head instruction
//   instr_pc_o     out  XLEN  PC of FIFO head
//   fifo_count_o   out  CW    entries currently in FIFO
//   halted_o       out  1     fetch PC has passed the last IMEM word
// BEHAVIOUR
//   Reset values (resetb_i=0, asynchronous): fetch_pc=RESET_PC; FIFO empty; in-flight read cleared;
//     instr_valid_o=0, instruction_o=0, instr_pc_o=0, fifo_count_o=0, halted_o=0. IMEM contents are not reset.
//   IMEM: single port with a synchronous 1-cycle read. Index = fetch_pc[AW+1:2].
//     A load has priority: no fetch is issued in a cycle with load_ena_i=1.
//   Fetch issue, cycle N, requires all of: run_i=1, !load_ena_i, !redirect_i, !halted_o,
//     and fifo_count_o + inflight < FIFO_DEPTH.
//     On issue: fetch_pc += 4. The word and its PC are pushed into the FIFO at the N+1 edge.
//     Latency: run_i rises at edge E with the FIFO empty -> instr_valid_o=1 after edge E+2.
//   FIFO: first-word-fall-through. Pop when instr_valid_o & instr_ready_i.
//     A push and a pop in the same cycle leave the count unchanged.
//     Pointers wrap modulo FIFO_DEPTH.
//     instruction_o and instr_pc_o hold stable while instr_valid_o=1 and instr_ready_i=0.
//     When the FIFO is empty, instruction_o holds its last value; it is don't-care while invalid.
//   FSM (2 bits):
//     IDLE  -> FETCH on run_i=1.
//     FETCH -> IDLE on run_i=0. The in-flight read still completes and is pushed.
//     FETCH -> HALT when an issue makes fetch_pc reach IMEM_DEPTH*4 or any higher value. No PC wrap-around.
//     HALT  -> FETCH on redirect_i to an in-range PC. halted_o=1 only in HALT.
//       The FIFO keeps draining while in HALT.
//   Redirect (priority over pop, push and issue in the same cycle):
//     - FIFO flushed, in-flight read discarded (never pushed).
//     - fetch_pc = {redirect_pc_i[XLEN-1:2],2'b00}; count=0.
//     - The next issue is earliest in the following cycle.
//     - Redirect to an out-of-range PC -> HALT; instr_valid_o stays 0.
//   Reset mid-operation aborts everything immediately; the pending IMEM read is discarded.
//   Arithmetic: PC is unsigned XLEN bits, +4. Bits [1:0] of fetch_pc are always 0.
// TESTING
//   1 Load 0x00108093,0x00108133,0x001101b3 at words 0..2; run_i=1, ready=1 -> outputs in order
//     with instr_pc_o 0x0,0x4,0x8; first valid two edges after run_i rises.
//   2 ready=0 with run_i=1 -> fifo_count_o saturates at 4 and never exceeds it; instruction_o=0x00108093
//     holds. Then ready=1 -> pcs 0x0,0x4,0x8,0xC pop with no loss or duplication.
//   3 FIFO full with head pc 0x0; redirect_i=1, redirect_pc_i=0x0000000A, with ready=1 in the same cycle
//     -> count=0 next cycle; next valid word is 0x001101b3 at pc 0x8.
//   4 IMEM_DEPTH=4, run_i=1, ready=1 -> pcs 0x0..0xC delivered; halted_o=1 after the 0xC issue; no pc 0x10.
//     Then redirect to 0x4 -> halted_o=0 and fetch resumes at 0x4.
//   5 load_ena_i pulsed every other cycle during run -> fetch stalls on load cycles; the loaded word is
//     returned when its address is fetched later.
//   6 resetb_i=0 asserted mid-run with 3 entries queued -> instr_valid_o=0 and fifo_count_o=0 immediately
//     (asynchronous). After release, run restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - loadable IMEM, program counter and prefetch FIFO with valid/ready output
module instr_fetch_queue #(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  localparam int AW = $clog2(IMEM_DEPTH),
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic            clock_i,
  input  logic            resetb_i,
  input  logic            load_ena_i,
  input  logic [AW-1:0]   load_addr_i,
  input  logic [XLEN-1:0] load_data_i,
  input  logic            run_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] instruction_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic [CW-1:0]   fifo_count_o,
  output logic            halted_o
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pc_next_seq;
  logic [XLEN-1:0] redir_pc;
  logic [XLEN-1:0] imem [IMEM_DEPTH];
  logic [XLEN-1:0] rd_data;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_pc [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   rd_ptr_nxt;
  logic [CW-1:0]   count_nxt;
  logic [CW:0]     occupancy;
  logic            issue;
  logic            push;
  logic            pop;
  logic            redir_oor;
  logic            seq_oor;

  // Out of range means any PC bit above the IMEM byte-address field is set.
  assign redir_pc    = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign redir_oor   = |redir_pc[XLEN-1:AW+2];
  assign pc_next_seq = fetch_pc + XLEN'(4);
  assign seq_oor     = |pc_next_seq[XLEN-1:AW+2];

  // Reserve a slot for the read in flight so a push never finds the FIFO full.
  assign occupancy = {1'b0, fifo_count_o} + {{CW{1'b0}}, inflight};
  assign issue     = (state == S_FETCH) && run_i && !load_ena_i && !redirect_i
                     && (occupancy < (CW+1)'(FIFO_DEPTH));
  assign push      = inflight && !redirect_i;
  assign pop       = instr_valid_o && instr_ready_i && !redirect_i;
  assign rd_ptr_nxt = pop ? rd_ptr + PW'(1) : rd_ptr;
  assign halted_o  = (state == S_HALT);

  always_comb begin
    count_nxt = fifo_count_o;
    if (push && !pop) begin
      count_nxt = fifo_count_o + CW'(1);
    end else if (!push && pop) begin
      count_nxt = fifo_count_o - CW'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (load_ena_i) begin
      imem[load_addr_i] <= load_data_i;
    end
    if (issue) begin
      rd_data <= imem[fetch_pc[AW+1:2]];
    end
  end

  always_ff @(posedge clock_i) begin
    if (push) begin
      fifo_data[wr_ptr] <= rd_data;
      fifo_pc[wr_ptr]   <= inflight_pc;
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state         <= S_IDLE;
      fetch_pc      <= RESET_PC;
      inflight      <= 1'b0;
      inflight_pc   <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count_o  <= '0;
      instr_valid_o <= 1'b0;
      instruction_o <= '0;
      instr_pc_o    <= '0;
    end else if (redirect_i) begin
      fetch_pc      <= redir_pc;
      inflight      <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count_o  <= '0;
      instr_valid_o <= 1'b0;
      if (redir_oor) begin
        state <= S_HALT;
      end else if (state == S_HALT || run_i) begin
        state <= S_FETCH;
      end else begin
        state <= S_IDLE;
      end
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= pc_next_seq;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr        <= rd_ptr_nxt;
      fifo_count_o  <= count_nxt;
      instr_valid_o <= (count_nxt != '0);
      // Head register: bypass the word being pushed when it becomes the new head.
      if (count_nxt != '0) begin
        if (push && (rd_ptr_nxt == wr_ptr)) begin
          instruction_o <= rd_data;
          instr_pc_o    <= inflight_pc;
        end else begin
          instruction_o <= fifo_data[rd_ptr_nxt];
          instr_pc_o    <= fifo_pc[rd_ptr_nxt];
        end
      end
      case (state)
        S_IDLE:  if (run_i) state <= S_FETCH;
        S_FETCH: begin
          if (issue && seq_oor) begin
            state <= S_HALT;
          end else if (!run_i) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - directed self-checking bench for instr_fetch_queue
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_ena;
  logic [5:0]  load_addr;
  logic [31:0] load_data;
  logic        run;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [2:0]  count;
  logic        halted;

  logic        s_load_ena;
  logic [1:0]  s_load_addr;
  logic [31:0] s_load_data;
  logic        s_run;
  logic        s_redirect;
  logic [31:0] s_redirect_pc;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_instr;
  logic [31:0] s_pc;
  logic [2:0]  s_count;
  logic        s_halted;

  int errors = 0;
  int checks = 0;
  logic [31:0] model [64];
  logic [31:0] pop_pc [$];
  logic [31:0] pop_instr [$];

  always #5 clk = ~clk;

  instr_fetch_queue dut (
    .clock_i(clk), .resetb_i(rst_n),
    .load_ena_i(load_ena), .load_addr_i(load_addr), .load_data_i(load_data),
    .run_i(run), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .instr_valid_o(valid), .instr_ready_i(ready), .instruction_o(instr),
    .instr_pc_o(pc), .fifo_count_o(count), .halted_o(halted)
  );

  instr_fetch_queue #(.IMEM_DEPTH(4)) dut4 (
    .clock_i(clk), .resetb_i(rst_n),
    .load_ena_i(s_load_ena), .load_addr_i(s_load_addr), .load_data_i(s_load_data),
    .run_i(s_run), .redirect_i(s_redirect), .redirect_pc_i(s_redirect_pc),
    .instr_valid_o(s_valid), .instr_ready_i(s_ready), .instruction_o(s_instr),
    .instr_pc_o(s_pc), .fifo_count_o(s_count), .halted_o(s_halted)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    run = 0; ready = 0; redirect = 0; load_ena = 0;
    s_run = 0; s_ready = 0; s_redirect = 0; s_load_ena = 0;
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic fill_fifo();
    run = 1; ready = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_eq("sat_le4", 32'(count <= 3'd4), 32'd1);
    end
    check_eq("sat_count", 32'(count), 32'd4);
    check_eq("sat_instr", instr, 32'h00108093);
    check_eq("sat_pc", pc, 32'h0);
  endtask

  initial begin
    load_addr = '0; load_data = '0; redirect_pc = '0;
    s_load_addr = '0; s_load_data = '0; s_redirect_pc = '0;
    for (int i = 0; i < 64; i++) model[i] = 32'h00000013 | (32'(i) << 7);
    model[0] = 32'h00108093;
    model[1] = 32'h00108133;
    model[2] = 32'h001101b3;

    do_reset();
    rst_n = 0;
    #1;
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_instr", instr, 32'd0);
    check_eq("rst_pc", pc, 32'd0);
    tick();
    rst_n = 1;

    for (int i = 0; i < 16; i++) begin
      load_ena = 1; load_addr = 6'(i); load_data = model[i];
      tick();
    end
    load_ena = 0;

    // Test 1: in-order delivery and two-edge latency
    run = 1; ready = 1;
    tick();
    check_eq("t1_lat_e0", 32'(valid), 32'd0);
    tick();
    check_eq("t1_lat_e1", 32'(valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t1_valid", 32'(valid), 32'd1);
      check_eq("t1_instr", instr, model[i]);
      check_eq("t1_pc", pc, 32'(4 * i));
    end

    // Test 2: saturation then lossless drain
    do_reset();
    fill_fifo();
    ready = 1;
    for (int i = 0; i < 5; i++) begin
      check_eq("t2_valid", 32'(valid), 32'd1);
      check_eq("t2_pc", pc, 32'(4 * i));
      check_eq("t2_instr", instr, model[i]);
      tick();
    end

    // Test 3: redirect with concurrent pop on a full FIFO
    do_reset();
    fill_fifo();
    redirect = 1; redirect_pc = 32'h0000000A; ready = 1;
    tick();
    redirect = 0;
    check_eq("t3_count", 32'(count), 32'd0);
    check_eq("t3_valid0", 32'(valid), 32'd0);
    tick();
    check_eq("t3_valid1", 32'(valid), 32'd0);
    tick();
    check_eq("t3_valid2", 32'(valid), 32'd1);
    check_eq("t3_instr", instr, 32'h001101b3);
    check_eq("t3_pc", pc, 32'h8);

    // Test 5: loads interleaved with fetch
    do_reset();
    run = 1; ready = 1;
    for (int c = 0; c < 32; c++) begin
      load_ena = (c % 2 == 0);
      if (c < 8) begin
        load_addr = 6'(8 + c / 2);
        load_data = 32'hA5A50000 + 32'(c);
      end else begin
        load_addr = 6'd40;
        load_data = 32'h0;
      end
      if (load_ena) model[load_addr] = load_data;
      if (valid && ready) begin
        pop_pc.push_back(pc);
        pop_instr.push_back(instr);
      end
      tick();
    end
    load_ena = 0;
    check_eq("t5_pops", 32'(pop_pc.size()), 32'd15);
    for (int i = 0; i < pop_pc.size(); i++) begin
      check_eq("t5_pc", pop_pc[i], 32'(4 * i));
      check_eq("t5_instr", pop_instr[i], model[i]);
    end

    // Test 6: asynchronous reset mid-run
    do_reset();
    run = 1; ready = 0;
    for (int i = 0; i < 5; i++) tick();
    check_eq("t6_count3", 32'(count), 32'd3);
    rst_n = 0;
    #2;
    check_eq("t6_valid_async", 32'(valid), 32'd0);
    check_eq("t6_count_async", 32'(count), 32'd0);
    #2;
    rst_n = 1;
    ready = 1;
    tick();
    check_eq("t6_lat_e0", 32'(valid), 32'd0);
    tick();
    check_eq("t6_lat_e1", 32'(valid), 32'd0);
    tick();
    check_eq("t6_valid", 32'(valid), 32'd1);
    check_eq("t6_pc", pc, 32'h0);
    check_eq("t6_instr", instr, model[0]);

    // Test 4: small IMEM halts at end, redirect resumes
    do_reset();
    for (int i = 0; i < 4; i++) begin
      s_load_ena = 1; s_load_addr = 2'(i); s_load_data = model[i];
      tick();
    end
    s_load_ena = 0;
    s_run = 1; s_ready = 1;
    tick();
    tick();
    tick();
    check_eq("t4_pc0", s_pc, 32'h0);
    tick();
    check_eq("t4_pc4", s_pc, 32'h4);
    check_eq("t4_halt0", 32'(s_halted), 32'd0);
    tick();
    check_eq("t4_pc8", s_pc, 32'h8);
    check_eq("t4_halt1", 32'(s_halted), 32'd1);
    tick();
    check_eq("t4_pcC", s_pc, 32'hC);
    check_eq("t4_validC", 32'(s_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t4_no_pc10", 32'(s_valid), 32'd0);
    end
    check_eq("t4_halt_hold", 32'(s_halted), 32'd1);
    s_redirect = 1; s_redirect_pc = 32'h4;
    tick();
    s_redirect = 0;
    check_eq("t4_resume", 32'(s_halted), 32'd0);
    tick();
    tick();
    check_eq("t4_rvalid", 32'(s_valid), 32'd1);
    check_eq("t4_rpc", s_pc, 32'h4);
    check_eq("t4_rinstr", s_instr, model[1]);
    s_redirect = 1; s_redirect_pc = 32'h10;
    tick();
    s_redirect = 0;
    check_eq("t4_oor_halt", 32'(s_halted), 32'd1);
    check_eq("t4_oor_valid", 32'(s_valid), 32'd0);
    tick();
    tick();
    check_eq("t4_oor_valid2", 32'(s_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
